// File: rtl/psum_drain.sv
// Psum collector: accumulates COLS-wide psum vectors over a configurable number
// of passes, then drains the per-column sums one beat at a time over valid/ready.

module psum_lane #(
    parameter int PSUM_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              add_en,
    input  logic [PSUM_W-1:0] psum,
    output logic [PSUM_W-1:0] acc,
    output logic              carry
);
    logic [PSUM_W-1:0] acc_q, acc_d;
    logic [PSUM_W:0]   sum;

    assign sum   = {1'b0, acc_q} + {1'b0, psum};
    assign carry = sum[PSUM_W];
    assign acc   = acc_q;

    always_comb begin
        acc_d = acc_q;
        if (clr)
            acc_d = '0;
        else if (add_en)
            acc_d = sum[PSUM_W-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            acc_q <= '0;
        else
            acc_q <= acc_d;
    end
endmodule

module psum_drain #(
    parameter int COLS   = 14,
    parameter int PSUM_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        passes_cfg,
    input  logic [PSUM_W-1:0] psum_vec [0:COLS-1],
    input  logic              psum_valid,
    output logic [PSUM_W-1:0] out_data,
    output logic [3:0]        out_col,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              ovf,
    output logic              overrun
);
    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

    localparam logic [3:0] LAST_COL = 4'(COLS - 1);

    state_t            state_q, state_d;
    logic [3:0]        passes_q, passes_d;
    logic [3:0]        pass_cnt_q, pass_cnt_d;
    logic [3:0]        col_q, col_d;
    logic [PSUM_W-1:0] out_data_q, out_data_d;
    logic [3:0]        out_col_q, out_col_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic              overrun_q, overrun_d;

    logic                         clr, add_en;
    logic [COLS-1:0][PSUM_W-1:0]  acc;
    logic [COLS-1:0]              carry;
    logic [3:0]                   load_col;

    for (genvar c = 0; c < COLS; c++) begin : g_lane
        psum_lane #(.PSUM_W(PSUM_W)) u_lane (
            .clk    (clk),
            .rst    (rst),
            .clr    (clr),
            .add_en (add_en),
            .psum   (psum_vec[c]),
            .acc    (acc[c]),
            .carry  (carry[c])
        );
    end

    // First beat of a drain loads col 0; afterwards each transfer loads the next column.
    assign load_col = out_valid_q ? col_q + 4'd1 : col_q;

    always_comb begin
        state_d     = state_q;
        passes_d    = passes_q;
        pass_cnt_d  = pass_cnt_q;
        col_d       = col_q;
        out_data_d  = out_data_q;
        out_col_d   = out_col_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;
        ovf_d       = ovf_q;
        overrun_d   = overrun_q;
        clr         = 1'b0;
        add_en      = 1'b0;

        if (psum_valid && state_q != ACCUM)
            overrun_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (start) begin
                    passes_d   = (passes_cfg == 4'd0) ? 4'd1 : passes_cfg;
                    pass_cnt_d = 4'd0;
                    ovf_d      = 1'b0;
                    overrun_d  = 1'b0;
                    clr        = 1'b1;
                    state_d    = ACCUM;
                end
            end
            ACCUM: begin
                if (psum_valid) begin
                    add_en     = 1'b1;
                    ovf_d      = ovf_q | (|carry);
                    pass_cnt_d = pass_cnt_q + 4'd1;
                    if (pass_cnt_q + 4'd1 == passes_q) begin
                        col_d   = 4'd0;
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!out_valid_q || (out_ready && !out_last_q)) begin
                    col_d       = load_col;
                    out_valid_d = 1'b1;
                    out_data_d  = acc[load_col];
                    out_col_d   = load_col;
                    out_last_d  = (load_col == LAST_COL);
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    done_d      = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            passes_q    <= '0;
            pass_cnt_q  <= '0;
            col_q       <= '0;
            out_data_q  <= '0;
            out_col_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            passes_q    <= passes_d;
            pass_cnt_q  <= pass_cnt_d;
            col_q       <= col_d;
            out_data_q  <= out_data_d;
            out_col_q   <= out_col_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_col   = out_col_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign done      = done_q;
    assign ovf       = ovf_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_psum_drain.sv
// Scoreboard bench for psum_drain: directed jobs push expected beats, a negedge
// monitor pops and compares every transfer and checks hold/done behaviour.

module tb_psum_drain;
    localparam int COLS = 14;
    localparam int W    = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [3:0]   passes_cfg = '0;
    logic [W-1:0] psum_vec [0:COLS-1];
    logic         psum_valid = 1'b0;
    logic [W-1:0] out_data;
    logic [3:0]   out_col;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic         out_last;
    logic         busy, done, ovf, overrun;

    psum_drain #(.COLS(COLS), .PSUM_W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .passes_cfg (passes_cfg),
        .psum_vec   (psum_vec),
        .psum_valid (psum_valid),
        .out_data   (out_data),
        .out_col    (out_col),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done),
        .ovf        (ovf),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]   col;
        logic [W-1:0] data;
        logic         last;
    } beat_t;

    beat_t sb[$];
    int    tests = 0;
    int    fails = 0;
    int    beats_seen = 0;
    bit    rdy_toggle = 1'b0;
    int    rdy_ph = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare each transfer, verify held beats and the done pulse.
    bit    last_prev = 1'b0;
    bit    hold_prev = 1'b0;
    beat_t hold_beat;
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            if (last_prev) begin
                check("done_after_last", {31'd0, done}, 1);
                check("valid_low_in_done", {31'd0, out_valid}, 0);
            end
            last_prev = 1'b0;
            if (hold_prev) begin
                check("hold_data", out_data, hold_beat.data);
                check("hold_col", {28'd0, out_col}, {28'd0, hold_beat.col});
            end
            hold_prev = 1'b0;
            if (out_valid && !out_ready) begin
                hold_prev = 1'b1;
                hold_beat = '{col: out_col, data: out_data, last: out_last};
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_beat: got col %0d data %0h expected none", out_col, out_data);
                end else begin
                    e = sb.pop_front();
                    check("beat_col", {28'd0, out_col}, {28'd0, e.col});
                    check("beat_data", out_data, e.data);
                    check("beat_last", {31'd0, out_last}, {31'd0, e.last});
                end
                beats_seen++;
                last_prev = out_last;
            end
        end else begin
            last_prev = 1'b0;
            hold_prev = 1'b0;
        end
    end

    // Ready pattern 1,0,0 repeating when enabled.
    always @(posedge clk) begin
        #1;
        if (rdy_toggle) begin
            out_ready = (rdy_ph == 0);
            rdy_ph    = (rdy_ph + 1) % 3;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [3:0] cfg);
        passes_cfg = cfg;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_valid();
        psum_valid = 1'b1;
        tick();
        psum_valid = 1'b0;
    endtask

    task automatic push_beat(input int c, input logic [W-1:0] d);
        sb.push_back('{col: 4'(c), data: d, last: (c == COLS - 1)});
    endtask

    task automatic wait_done(input string name, input int limit);
        bit seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got no done expected done within %0d cycles", name, limit);
        end
        @(negedge clk);
        check({name, "_done_one_cycle"}, {31'd0, done}, 0);
        check({name, "_idle"}, {31'd0, busy}, 0);
        tick();
    endtask

    initial begin
        int base;
        bit hit;
        for (int c = 0; c < COLS; c++) psum_vec[c] = '0;

        // Reset state
        #12;
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_out_last", {31'd0, out_last}, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_col", {28'd0, out_col}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_ovf", {31'd0, ovf}, 0);
        check("rst_overrun", {31'd0, overrun}, 0);
        #3 rst = 1'b1;
        tick();

        // Basic job: 6 passes of c+1 -> 6*(c+1)
        do_start(4'd6);
        check("busy_after_start", {31'd0, busy}, 1);
        for (int c = 0; c < COLS; c++) begin
            psum_vec[c] = W'(c + 1);
            push_beat(c, W'(6 * (c + 1)));
        end
        repeat (6) pulse_valid();
        wait_done("basic", 60);
        check("basic_ovf", {31'd0, ovf}, 0);
        check("basic_overrun", {31'd0, overrun}, 0);

        // Same job under backpressure
        rdy_toggle = 1'b1;
        do_start(4'd6);
        for (int c = 0; c < COLS; c++) push_beat(c, W'(6 * (c + 1)));
        repeat (6) pulse_valid();
        wait_done("bp", 120);
        rdy_toggle = 1'b0;
        out_ready = 1'b1;

        // Zero passes treated as one, with idle gap before the valid
        do_start(4'd0);
        repeat (3) tick();
        for (int c = 0; c < COLS; c++) begin
            psum_vec[c] = 32'h0000_0100;
            push_beat(c, 32'h0000_0100);
        end
        pulse_valid();
        wait_done("gap", 60);

        // Overflow on lane 0
        do_start(4'd2);
        for (int c = 0; c < COLS; c++) psum_vec[c] = '0;
        psum_vec[0] = 32'hFFFF_FFFF;
        pulse_valid();
        psum_vec[0] = 32'h0000_0002;
        pulse_valid();
        push_beat(0, 32'h0000_0001);
        for (int c = 1; c < COLS; c++) push_beat(c, 32'h0);
        wait_done("ovf", 60);
        check("ovf_set", {31'd0, ovf}, 1);

        // Misuse: start and psum_valid while draining; ovf cleared by new start
        do_start(4'd1);
        check("ovf_cleared", {31'd0, ovf}, 0);
        for (int c = 0; c < COLS; c++) begin
            psum_vec[c] = W'(3 * c);
            push_beat(c, W'(3 * c));
        end
        pulse_valid();
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk);
            if (out_valid) hit = 1'b1;
        end
        check("misuse_drain_seen", {31'd0, hit}, 1);
        tick();
        for (int c = 0; c < COLS; c++) psum_vec[c] = 32'hFF;
        start = 1'b1;
        psum_valid = 1'b1;
        tick();
        start = 1'b0;
        psum_valid = 1'b0;
        wait_done("misuse", 60);
        check("misuse_overrun", {31'd0, overrun}, 1);
        check("misuse_ovf", {31'd0, ovf}, 0);

        // Reset during drain after 5 beats
        do_start(4'd1);
        for (int c = 0; c < COLS; c++) begin
            psum_vec[c] = W'(c + 100);
            push_beat(c, W'(c + 100));
        end
        base = beats_seen;
        pulse_valid();
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk);
            if (beats_seen >= base + 5) hit = 1'b1;
        end
        check("rst_drain_5_beats", {31'd0, hit}, 1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_mid_valid", {31'd0, out_valid}, 0);
        check("rst_mid_busy", {31'd0, busy}, 0);
        check("rst_mid_overrun", {31'd0, overrun}, 0);
        sb.delete();
        #13 rst = 1'b1;
        tick();
        check("rst_hold_valid", {31'd0, out_valid}, 0);

        // Fresh job after reset
        do_start(4'd1);
        for (int c = 0; c < COLS; c++) begin
            psum_vec[c] = W'(c + 1);
            push_beat(c, W'(c + 1));
        end
        pulse_valid();
        wait_done("post_rst", 60);

        check("sb_empty", W'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
